// File: rtl/filter_cfg_pkg.sv
// Shared definitions for filter_cfg_sequencer: register map, FSM states and
// the coefficient/threshold bank layout used by both shadow and active copies.
package filter_cfg_pkg;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_STATUS = 4'd1;
  localparam logic [3:0] A_COEF0  = 4'd2;
  localparam logic [3:0] A_COEF8  = 4'd10;
  localparam logic [3:0] A_THR    = 4'd11;
  localparam logic [3:0] A_IRQ    = 4'd12;

  // Filter_Pipe mode encodings; 6 and 7 are forwarded untouched.
  localparam logic [2:0] MODE_0 = 3'd0;
  localparam logic [2:0] MODE_1 = 3'd1;
  localparam logic [2:0] MODE_2 = 3'd2;
  localparam logic [2:0] MODE_3 = 3'd3;
  localparam logic [2:0] MODE_4 = 3'd4;
  localparam logic [2:0] MODE_5 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PENDING, S_FLUSH, S_COMMIT
  } state_e;

  // coef[0] = c_m1_m1 ... coef[8] = c_p1_p1, row-major.
  typedef struct packed {
    logic [8:0][7:0] coef;
    logic [7:0]      thr;
  } coef_set_t;

endpackage

// File: rtl/filter_cfg_regfile.sv
// Avalon-MM decode, shadow register bank and registered readback.
// Define FILTER_CFG_SEQ_IRQ_EN to add the commit-done IRQ register at address 12.
module filter_cfg_regfile
  import filter_cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  addr_i,
  input  logic        cs_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        pending_i,
  input  logic        enable_i,
  input  logic        busy_i,
  input  logic [7:0]  commit_cnt_i,
  input  logic        commit_done_i,
  output logic        sh_en_o,
  output logic [2:0]  sh_mode_o,
  output coef_set_t   shadow_o,
  output logic        commit_req_o,
  output logic        irq_o
);

  logic        wr, rd, is_coef;
  logic [3:0]  cidx;
  logic        en_q, en_d;
  logic [2:0]  mode_q, mode_d;
  coef_set_t   sh_q, sh_d;
  logic [31:0] rdata_q, rdata_d, irq_word;
  logic        unused_wdata;

  assign wr           = cs_i & wr_i;
  assign rd           = cs_i & rd_i;
  assign is_coef      = (addr_i >= A_COEF0) && (addr_i <= A_COEF8);
  assign cidx         = addr_i - A_COEF0;
  assign commit_req_o = wr && (addr_i == A_CTRL) && wdata_i[4];
  assign unused_wdata = ^wdata_i[31:8];

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    sh_d   = sh_q;
    if (wr) begin
      if (addr_i == A_CTRL) begin
        en_d   = wdata_i[0];
        mode_d = wdata_i[3:1];
      end
      if (is_coef) sh_d.coef[cidx] = wdata_i[7:0];
      if (addr_i == A_THR) sh_d.thr = wdata_i[7:0];
    end
  end

`ifdef FILTER_CFG_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d, done_q, done_d, irq_q;

  // A commit landing on the same cycle as a clear keeps the flag set.
  always_comb begin
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (wr && addr_i == A_IRQ) begin
      irq_en_d = wdata_i[0];
      if (wdata_i[1]) done_d = 1'b0;
    end
    if (commit_done_i) done_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_en_d & done_d;
    end
  end

  assign irq_word = {30'b0, done_q, irq_en_q};
  assign irq_o    = irq_q;
`else
  logic unused_done;
  assign unused_done = commit_done_i;
  assign irq_word    = '0;
  assign irq_o       = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      if (is_coef) rdata_d[7:0] = sh_q.coef[cidx];
      case (addr_i)
        A_CTRL:   rdata_d[3:0]  = {mode_q, en_q};
        A_STATUS: rdata_d[15:0] = {commit_cnt_i, 5'b0, busy_i, enable_i, pending_i};
        A_THR:    rdata_d[7:0]  = sh_q.thr;
        A_IRQ:    rdata_d       = irq_word;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      mode_q  <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign sh_en_o   = en_q;
  assign sh_mode_o = mode_q;
  assign shadow_o  = sh_q;

endmodule

// File: rtl/filter_cfg_sequencer.sv
// Frame-safe configuration sequencer for Filter_Pipe: shadow registers are
// copied to the active bank only at a blanking boundary after a flush window.
// Optional commit-done IRQ enabled by defining FILTER_CFG_SEQ_IRQ_EN.
module filter_cfg_sequencer
  import filter_cfg_pkg::*;
#(
  parameter int         FLUSH_CYCLES = 4,
  parameter logic [9:0] COMMIT_LINE  = 10'd1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Clock_en,
  input  logic [10:0] H_Count,
  input  logic [9:0]  V_Count,
  input  logic [3:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        Enable,
  output logic [31:0] Filter_config,
  output logic [7:0]  c_m1_m1, c_m1_0, c_m1_p1,
  output logic [7:0]  c_0_m1,  c_0_0,  c_0_p1,
  output logic [7:0]  c_p1_m1, c_p1_0, c_p1_p1,
  output logic [7:0]  threshhold_val,
  output logic        irq
);

  localparam int            CW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    ccnt_q, ccnt_d;
  logic          pend_q, pend_d, relat_q, relat_d, en_hold_q;
  logic [2:0]    act_mode_q, sh_mode;
  coef_set_t     act_q, shadow;
  logic          sh_en, commit_req, boundary, busy, in_commit;

  assign boundary  = Clock_en && (V_Count == COMMIT_LINE) && (H_Count == '0);
  assign in_commit = (state_q == S_COMMIT);

  filter_cfg_regfile u_regfile (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .addr_i       (avs_address),
    .cs_i         (avs_chipselect),
    .rd_i         (avs_read),
    .wr_i         (avs_write),
    .wdata_i      (avs_writedata),
    .rdata_o      (avs_readdata),
    .pending_i    (pend_q),
    .enable_i     (Enable),
    .busy_i       (busy),
    .commit_cnt_i (ccnt_q),
    .commit_done_i(in_commit),
    .sh_en_o      (sh_en),
    .sh_mode_o    (sh_mode),
    .shadow_o     (shadow),
    .commit_req_o (commit_req),
    .irq_o        (irq)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      fcnt_q     <= '0;
      ccnt_q     <= '0;
      pend_q     <= 1'b0;
      relat_q    <= 1'b0;
      en_hold_q  <= 1'b0;
      act_q      <= '0;
      act_mode_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      ccnt_q    <= ccnt_d;
      pend_q    <= pend_d;
      relat_q   <= relat_d;
      en_hold_q <= Enable;
      if (in_commit) begin
        act_q      <= shadow;
        act_mode_q <= sh_mode;
      end
    end
  end

  // Requests arriving while flushing/committing are remembered and replayed as a new PENDING.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    ccnt_d  = ccnt_q;
    pend_d  = pend_q | commit_req;
    relat_d = relat_q;
    case (state_q)
      S_IDLE, S_RUN: if (commit_req) state_d = S_PENDING;
      S_PENDING: if (boundary) begin
        state_d = S_FLUSH;
        fcnt_d  = FLUSH_LOAD;
      end
      S_FLUSH: begin
        if (commit_req) relat_d = 1'b1;
        if (Clock_en) begin
          if (fcnt_q == '0) state_d = S_COMMIT;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
      end
      S_COMMIT: begin
        ccnt_d  = ccnt_q + 8'd1;
        relat_d = 1'b0;
        pend_d  = relat_q | commit_req;
        if (relat_q | commit_req) state_d = S_PENDING;
        else if (sh_en)           state_d = S_RUN;
        else                      state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Enable = 1'b0;
    busy   = 1'b1;
    case (state_q)
      S_IDLE:    busy   = 1'b0;
      S_RUN:     begin Enable = 1'b1; busy = 1'b0; end
      S_PENDING: Enable = en_hold_q;
      default:   Enable = 1'b0;
    endcase
  end

  assign Filter_config  = {29'b0, act_mode_q};
  assign c_m1_m1        = act_q.coef[0];
  assign c_m1_0         = act_q.coef[1];
  assign c_m1_p1        = act_q.coef[2];
  assign c_0_m1         = act_q.coef[3];
  assign c_0_0          = act_q.coef[4];
  assign c_0_p1         = act_q.coef[5];
  assign c_p1_m1        = act_q.coef[6];
  assign c_p1_0         = act_q.coef[7];
  assign c_p1_p1        = act_q.coef[8];
  assign threshhold_val = act_q.thr;

endmodule

// File: doc/filter_cfg_sequencer.md
Name: filter_cfg_sequencer

Overview:
- Nios-facing Avalon-MM slave. Holds a shadow copy of every Filter_Pipe control input: enable, mode, nine signed 3x3 coefficients and the threshold.
- Software writes the shadow registers, then requests a commit. The sequencer waits for a vertical-blanking boundary, drops Enable for a flush window, copies shadow to active, then re-enables the pipe.
- Sits between the Nios bus and Filter_Pipe so coefficient and mode changes never tear a frame.

Parameters:
- FLUSH_CYCLES, default 4: number of Clock_en-qualified cycles Enable is held low before a commit.
- COMMIT_LINE, default 10'd1: V_Count value on which a commit may start. It must lie inside vertical blanking, i.e. below 33.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Clock_en  in  1  pixel-rate qualifier, shared with Filter_Pipe
- H_Count  in  11  horizontal timing count
- V_Count  in  10  vertical timing count
- avs_address  in  4  word address
- avs_chipselect  in  1  slave select
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  registered read data, 1-cycle latency
- Enable  out  1  Filter_Pipe enable
- Filter_config  out  32  active mode; bits [2:0] used, [31:3] zero
- c_m1_m1, c_m1_0, c_m1_p1, c_0_m1, c_0_0, c_0_p1, c_p1_m1, c_p1_0, c_p1_p1  out  8 each  active signed coefficients
- threshhold_val  out  8  active unsigned threshold
- irq  out  1  commit-done interrupt; present only with the optional feature, else tied 0

Behaviour:
- Register map, by word address:
  - 0 CTRL (R/W): [0] enable, [3:1] mode, [4] commit request. Bit 4 is write-1, self-clearing and reads 0.
  - 1 STATUS (RO): [0] pending (commit requested, not yet done), [1] Enable, [2] busy (state is not RUN/IDLE), [15:8] commit counter (wraps 255->0).
  - 2..10: shadow coefficients in row-major order, c_m1_m1 at 2 through c_p1_p1 at 10; bits [7:0].
  - 11: shadow threshold, [7:0].
  - 12: IRQ register (optional feature).
  - 13..15: read 0; writes ignored.
- Writes/reads: writes take effect in the cycle after the strobe. avs_readdata is valid the cycle after avs_read & avs_chipselect and holds its value otherwise.
- Boundary pulse: a one-cycle pulse when Clock_en & (V_Count == COMMIT_LINE) & (H_Count == 0).
- FSM states: IDLE, RUN, PENDING, FLUSH, COMMIT.
  - IDLE: active enable is 0 and Enable = 0. A commit request -> PENDING.
  - RUN: Enable = 1. A commit request -> PENDING.
  - PENDING: Enable keeps its prior value. Boundary pulse -> FLUSH.
  - FLUSH: Enable = 0. A counter loads FLUSH_CYCLES-1 and decrements on Clock_en; at 0 -> COMMIT.
  - COMMIT: one cycle. Copy all shadow registers to active, increment the commit counter, clear pending. Then go to RUN if shadow enable = 1, else IDLE. Enable updates the cycle after COMMIT.
- Shadow writes during PENDING or FLUSH are allowed; the values present on the COMMIT cycle win.
- A commit request while PENDING is absorbed (no effect). A commit request during FLUSH or COMMIT is latched and re-enters PENDING right after COMMIT.
- A request on the same cycle as the boundary pulse while in RUN goes to PENDING; FLUSH waits for the next frame.
- Reset (any time, including mid-FLUSH): state IDLE; all shadow and active registers 0; Enable 0; Filter_config 0; counters 0; pending 0; avs_readdata 0; irq 0.
- Mode values 6 and 7 pass through unchanged. Filter_pipe holds its previous output in those modes.

Optional Feature:
- Macro: FILTER_CFG_SEQ_IRQ_EN.
- Defined:
  - Address 12 is IRQ: [0] irq_enable (R/W), [1] done flag.
  - The done flag is set on the COMMIT cycle and cleared by writing 1 to bit 1; a set on the same cycle as a clear wins.
  - irq = irq_enable & done, registered.
- Undefined: address 12 reads 0, writes are ignored, irq is constant 0.

Decomposition:
- Package filter_cfg_pkg holds:
  - Register address localparams.
  - FSM state enum.
  - A packed struct of the coefficient and threshold set, used for both shadow and active banks.
  - Mode localparams 0-5.
- One sub-module, filter_cfg_regfile: Avalon decode, shadow bank and readback. The FSM and the active bank stay in the top.

Test Plan:
- Reset, then read addresses 0-11: all 0, Enable = 0, irq = 0.
- Write coef c_0_0 = 8'hFC and threshold = 8'd40, CTRL = 0x1B (enable, mode 5, commit).
  - STATUS pending = 1.
  - At V_Count = 1, H_Count = 0: Enable = 0 for 4 Clock_en cycles.
  - Then c_0_0 = 8'hFC, threshhold_val = 40, Filter_config = 5, Enable = 1, commit counter = 1.
- While PENDING, rewrite c_0_0 = 8'h08: the committed value is 8'h08.
- Write commit during FLUSH: a second FLUSH/COMMIT follows on the next frame boundary; commit counter ends at 2.
- Assert Reset mid-FLUSH: Enable = 0, state IDLE, active c_0_0 = 0, pending = 0.
- With FILTER_CFG_SEQ_IRQ_EN: set irq_enable; after commit, irq = 1; write 0x2 to address 12 -> irq = 0 next cycle.
